// File: rtl/mm_pkg.sv
// Shared types and constants for the 2x2 signed 2-bit matrix multiplier slice.
package mm_pkg;

  localparam int ELEM_W   = 2;  // operand element width, two's complement
  localparam int RES_W    = 4;  // result element width, two's complement
  localparam int NUM_ELEM = 4;  // elements per packed byte

  // -2 is representable in 2 bits but outside the tile's supported range
  localparam logic [ELEM_W-1:0] ELEM_ILLEGAL = 2'b10;

  // Packed byte layout {x22,x21,x12,x11}
  localparam int OFF_X11 = 0;
  localparam int OFF_X12 = 2;
  localparam int OFF_X21 = 4;
  localparam int OFF_X22 = 6;
  localparam int ELEM_OFF [NUM_ELEM] = '{OFF_X11, OFF_X12, OFF_X21, OFF_X22};

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    ISSUE,
    WAIT,
    OUT0,
    OUT1
  } state_t;

endpackage

// File: rtl/mm_operand_sequencer_if.sv
// Host byte streams plus the multiplier operand/result bus.
// master = sequencer side, slave = host and multiplier tile side.
interface mm_operand_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mm_a;
  logic [7:0] mm_b;
  logic       mm_ena;
  logic [7:0] mm_c0;
  logic [7:0] mm_c1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_err;

  modport master (
    input  in_data, in_valid, mm_c0, mm_c1, out_ready,
    output in_ready, mm_a, mm_b, mm_ena, out_data, out_valid, out_err
  );

  modport slave (
    output in_data, in_valid, mm_c0, mm_c1, out_ready,
    input  in_ready, mm_a, mm_b, mm_ena, out_data, out_valid, out_err
  );
endinterface

// File: rtl/mm_range_check.sv
// Flags a packed operand byte that contains any -2 element.
module mm_range_check
  import mm_pkg::*;
(
  input  logic [7:0] data,
  output logic       invalid
);

  logic [NUM_ELEM-1:0] bad;

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_elem
    assign bad[i] = (data[ELEM_OFF[i] +: ELEM_W] == ELEM_ILLEGAL);
  end

  assign invalid = |bad;

endmodule

// File: rtl/mm_operand_sequencer.sv
// Front end for the 2x2 matrix multiplier tile: collects A/B bytes,
// range-checks them, enables the tile, waits for the registered product
// and streams the two result bytes back.
module mm_operand_sequencer
  import mm_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,  // 1..15, ena-to-capture distance in edges
  parameter int CNT_W       = 4   // 2**CNT_W > WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  mm_operand_sequencer_if.master bus,
  output logic                   busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       hold;     // c1 parked while c0 is on the output
  logic             err;      // sticky range error for the current transaction
  logic             in_bad;
  logic             in_xfer;
  logic             out_xfer;

  // One checker serves both operand bytes; only one is on in_data at a time
  mm_range_check u_chk (
    .data    (bus.in_data),
    .invalid (in_bad)
  );

  // in_ready is gated by reset so it is already low during the reset cycle
  assign bus.in_ready  = !reset && (state == GET_A || state == GET_B);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == OUT0 || state == OUT1);
  assign out_xfer      = bus.out_valid && bus.out_ready;
  // Held from ISSUE through the last WAIT cycle, so the tile sees it for
  // WAIT_CYCLES+1 edges and capture lands WAIT_CYCLES edges after the first
  assign bus.mm_ena    = (state == ISSUE || state == WAIT);
  assign busy          = (state != GET_A);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= GET_A;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (in_xfer) state_nxt = GET_B;
      GET_B:   if (in_xfer) state_nxt = (err || in_bad) ? OUT0 : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = OUT0;
      OUT0:    if (out_xfer) state_nxt = OUT1;
      OUT1:    if (out_xfer) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  // Operand latches, wait counter, error flag and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mm_a     <= '0;
      bus.mm_b     <= '0;
      bus.out_data <= '0;
      bus.out_err  <= 1'b0;
      err          <= 1'b0;
      cnt          <= '0;
      hold         <= '0;
    end else begin
      case (state)
        GET_A: if (in_xfer) begin
          bus.mm_a <= bus.in_data;
          err      <= in_bad;
        end
        GET_B: if (in_xfer) begin
          bus.mm_b <= bus.in_data;
          err      <= err | in_bad;
          // Rejected transactions skip the tile and return two zero bytes
          if (err || in_bad) begin
            bus.out_data <= 8'h00;
            bus.out_err  <= 1'b1;
          end
        end
        ISSUE: cnt <= CNT_W'(WAIT_CYCLES - 1);
        WAIT: begin
          if (cnt == '0) begin
            bus.out_data <= bus.mm_c0;
            hold         <= bus.mm_c1;
            bus.out_err  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        OUT0: if (out_xfer) bus.out_data <= err ? 8'h00 : hold;
        // mm_a/mm_b intentionally keep the last operands
        OUT1: if (out_xfer) begin
          err         <= 1'b0;
          bus.out_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_operand_sequencer.sv
// Bench for mm_operand_sequencer: directed scenarios followed by randomized
// transactions, checked against a matrix-arithmetic reference model.
module tb_mm_operand_sequencer;
  localparam int W = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  mm_operand_sequencer_if bus ();

  mm_operand_sequencer #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Signed value of element idx (0=x11,1=x12,2=x21,3=x22)
  function automatic int elem(input logic [7:0] v, input int idx);
    int f;
    f = int'((v >> (2 * idx)) & 8'h03);
    return (f >= 2) ? f - 4 : f;
  endfunction

  function automatic bit is_bad(input logic [7:0] v);
    for (int k = 0; k < 4; k++) if (elem(v, k) == -2) return 1'b1;
    return 1'b0;
  endfunction

  // C = A x B, returned as {c1, c0} = {c22,c21,c12,c11}
  function automatic logic [15:0] product(input logic [7:0] a, input logic [7:0] b);
    int am [2][2];
    int bm [2][2];
    int c;
    logic [3:0] n [4];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        am[i][j] = elem(a, 2 * i + j);
        bm[i][j] = elem(b, 2 * i + j);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = 0;
        for (int k = 0; k < 2; k++) c += am[i][k] * bm[k][j];
        n[2 * i + j] = c[3:0];
      end
    return {n[3], n[2], n[1], n[0]};
  endfunction

  // Mostly legal elements, occasionally -2
  function automatic logic [7:0] rand_byte();
    logic [7:0] v;
    int r;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 15);
      v[2 * k +: 2] = (r == 0) ? 2'b10 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b11;
    end
    return v;
  endfunction

  // Multiplier tile: registers the product on an enabled edge; any edge
  // without enable leaves an out-of-range pattern so a mistimed capture shows
  always @(posedge clk) begin
    if (bus.mm_ena) {bus.mm_c1, bus.mm_c0} <= product(bus.mm_a, bus.mm_b);
    else            {bus.mm_c1, bus.mm_c0} <= 16'h7777;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; st0/st1 = stall cycles in OUT0/OUT1,
  // hold_v keeps in_valid high with nxt on in_data after the B byte
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int st0,
                         input int st1, input bit hold_v, input logic [7:0] nxt);
    logic [15:0] c;
    bit          bad;
    bit          leak;
    int          lat;
    int          ena_n;
    bad  = is_bad(a) || is_bad(b);
    c    = bad ? 16'h0000 : product(a, b);
    leak = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    chk("rdy_a", 16'(bus.in_ready), 16'd1);
    tick();
    chk("mm_a", 16'(bus.mm_a), 16'(a));
    chk("rdy_b", 16'(bus.in_ready), 16'd1);
    bus.in_data = b;
    tick();
    chk("mm_b", 16'(bus.mm_b), 16'(b));
    bus.in_valid = hold_v;
    bus.in_data  = nxt;
    lat   = 0;
    ena_n = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.mm_ena === 1'b1) ena_n++;
      if (bus.in_ready !== 1'b0) leak = 1'b1;
      tick();
      lat++;
    end
    chk("latency", 16'(lat), bad ? 16'd0 : 16'(W + 1));
    chk("ena_cycles", 16'(ena_n), bad ? 16'd0 : 16'(W + 1));
    for (int s = 0; s < st0; s++) begin
      chk("o0_stall_v", 16'(bus.out_valid), 16'd1);
      chk("o0_stall_d", 16'(bus.out_data), 16'(c[7:0]));
      leak |= bus.in_ready;
      tick();
    end
    chk("o0_valid", 16'(bus.out_valid), 16'd1);
    chk("o0_data", 16'(bus.out_data), 16'(c[7:0]));
    chk("o0_err", 16'(bus.out_err), 16'(bad));
    leak |= bus.in_ready;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int s = 0; s < st1; s++) begin
      chk("o1_stall_d", 16'(bus.out_data), 16'(c[15:8]));
      leak |= bus.in_ready;
      tick();
    end
    chk("o1_valid", 16'(bus.out_valid), 16'd1);
    chk("o1_data", 16'(bus.out_data), 16'(c[15:8]));
    chk("o1_err", 16'(bus.out_err), 16'(bad));
    leak |= bus.in_ready;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ready_leak", 16'(leak), 16'd0);
    chk("end_valid", 16'(bus.out_valid), 16'd0);
    chk("end_busy", 16'(busy), 16'd0);
    chk("end_ready", 16'(bus.in_ready), 16'd1);
    chk("end_mm_a", 16'(bus.mm_a), 16'(a));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ra, rb, na;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    chk("rst_mm_a", 16'(bus.mm_a), 16'd0);
    chk("rst_mm_b", 16'(bus.mm_b), 16'd0);
    chk("rst_out_data", 16'(bus.out_data), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_err", 16'(bus.out_err), 16'd0);
    chk("rst_ena", 16'(bus.mm_ena), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 16'(bus.in_ready), 16'd1);
    tick();

    // Identity times B, then all -1, then an illegal A
    run_txn(8'h41, 8'h4D, 0, 0, 1'b0, 8'h00);
    run_txn(8'hFF, 8'hFF, 0, 0, 1'b0, 8'h00);
    run_txn(8'h02, 8'h00, 0, 0, 1'b0, 8'h00);
    // Illegal B only, error flag comes from the second byte
    run_txn(8'h41, 8'h80, 1, 2, 1'b0, 8'h00);
    // Output stall in OUT0
    run_txn(8'h41, 8'h4D, 5, 0, 1'b0, 8'h00);

    // Reset in the middle of WAIT
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    tick();
    bus.in_data = 8'h4D;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_ena", 16'(bus.mm_ena), 16'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ena", 16'(bus.mm_ena), 16'd0);
    chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_ready", 16'(bus.in_ready), 16'd0);
    chk("mid_rst_mm_a", 16'(bus.mm_a), 16'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready_rel", 16'(bus.in_ready), 16'd1);
    tick();
    run_txn(8'h41, 8'h4D, 0, 0, 1'b0, 8'h00);

    // Back-to-back with in_valid held high
    run_txn(8'h41, 8'h4D, 0, 0, 1'b1, 8'hFF);
    run_txn(8'hFF, 8'hFF, 0, 0, 1'b1, 8'h44);
    run_txn(8'h44, 8'h11, 0, 1, 1'b0, 8'h00);

    // Randomized transactions
    na = rand_byte();
    for (int t = 0; t < 40; t++) begin
      ra = na;
      rb = rand_byte();
      na = rand_byte();
      run_txn(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), na);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mm_operand_sequencer.md
Name: mm_operand_sequencer

Overview:
Host-side front end for the 2x2 signed 2-bit matrix multiplier tile. It accepts operand bytes for A and B over a valid/ready byte stream and range-checks every element. It then drives the packed operand buses and enable into the multiplier, waits for the registered product, captures both result bytes and streams them back over a valid/ready byte stream. Invalid operands are rejected locally and the multiplier is never enabled.

Parameters:
WAIT_CYCLES, 2, cycles from mm_ena assertion to result capture (operand settle plus multiplier register); legal range 1..15
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_CYCLES

Ports:
clk  in  1  single clock domain
reset  in  1  synchronous, active-high reset
in_data  in  8  operand byte: first byte A, second byte B; packing {x22,x21,x12,x11}, 2 bits each, two's complement
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts in_data this cycle
mm_a  out  8  packed A to multiplier operand bus
mm_b  out  8  packed B to multiplier operand bus
mm_ena  out  1  multiplier enable
mm_c0  in  8  multiplier result byte 0 {c12[3:0],c11[3:0]}
mm_c1  in  8  multiplier result byte 1 {c22[3:0],c21[3:0]}
out_data  out  8  result byte: c0 first, then c1
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_err  out  1  qualifies out_valid: current transaction rejected for range
busy  out  1  high in any state other than GET_A

Behaviour:
- Reset (clk edge with reset=1) forces the following, with priority over everything, including mid-transaction:
  - state GET_A;
  - mm_a, mm_b, out_data, out_valid, out_err, mm_ena, busy all 0;
  - counter 0.
  - in_ready is 0 while reset is asserted and 1 in the first cycle after.
- Handshakes:
  - A transfer occurs on a clk edge where valid and ready are both 1.
  - out_data and out_err stay stable while out_valid=1 and out_ready=0.
  - out_valid does not drop without a transfer.
- Range check:
  - Element code 2'b10 (-2) is illegal. Legal codes are -1, 0, +1.
  - A byte is invalid if any of its four fields is 2'b10.
  - The error flag is sticky across A and B of one transaction and cleared on return to GET_A.
- FSM:
  - GET_A: in_ready=1. On transfer, latch the byte into mm_a and record its invalid flag. Go to GET_B.
  - GET_B: in_ready=1. On transfer, latch the byte into mm_b. If the error flag (A or B) is set, go to OUT0 with out_data=0x00 and out_err=1. Otherwise go to ISSUE.
  - ISSUE: mm_ena=1, counter loaded with WAIT_CYCLES-1. Go to WAIT. mm_ena stays 1 through WAIT.
  - WAIT: counter decrements each cycle. When it reaches 0, capture mm_c0 into out_data, capture mm_c1 into a holding register, drop mm_ena, set out_err=0. Go to OUT0.
  - OUT0: out_valid=1. On transfer, out_data becomes the holding register (or 0x00 if error). Go to OUT1.
  - OUT1: out_valid=1. On transfer, go to GET_A with out_valid=0 and mm_a/mm_b held (not cleared).
- in_ready is 0 in ISSUE, WAIT, OUT0 and OUT1. Input bytes are not buffered.
- Capture timing: capture happens exactly WAIT_CYCLES clk edges after the first edge at which mm_ena=1 is seen by the multiplier.
- Result fields are 4-bit two's complement with legal range -2..+2. The sequencer passes them unmodified and does not re-check them.
- Per-transaction latency with ready always high:
  - Valid transaction: 2 input cycles, 1 ISSUE cycle, WAIT_CYCLES wait cycles, 2 output cycles.
  - Error transaction: 2 input cycles, then 2 output cycles.
- Back-to-back transactions: the GET_A byte can be accepted in the cycle after the OUT1 transfer.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum (GET_A, GET_B, ISSUE, WAIT, OUT0, OUT1);
  - ELEM_W=2 and RES_W=4;
  - the illegal element code 2'b10;
  - byte field offsets.
- One natural sub-module: mm_range_check. It is combinational; 8-bit byte in, 1-bit invalid out. It is reused by the multiplier tile's own error logic.

Test Plan:
- A=0x41 (identity), B=0x4D (b11=1, b12=-1, b21=0, b22=1), ready high -> mm_ena high for exactly WAIT_CYCLES+1 cycles; out bytes 0xF1 then 0x10; out_err=0.
- A=0xFF, B=0xFF (all -1) -> every c=+2; out bytes 0x22 then 0x22.
- A=0x02 (a11=-2), B=0x00 -> mm_ena never asserts; out bytes 0x00, 0x00 with out_err=1 on both; state back to GET_A after 4 cycles.
- Identity case with out_ready held low for 5 cycles in OUT0 -> out_data=0xF1 and out_valid stable throughout; 0x10 appears only after the transfer.
- Reset pulsed during WAIT -> next edge: mm_ena=0, out_valid=0, busy=0, in_ready=1 after reset deasserts; a fresh A=0x41/B=0x4D then completes correctly.
- Two back-to-back transactions with in_valid held high -> second A is accepted the cycle after the first OUT1 transfer; in_ready=0 throughout the first ISSUE..OUT1.
